// File: rtl/homing_sequencer.sv
// Homing controller: arms on start, waits for a qualified index (Z) edge in the requested
// direction, captures the count and strobes a counter rebase. Optional timer: HOMING_TIMEOUT_EN.
module homing_sequencer #(
  parameter int CW = 16,
  parameter int TW = 24,
  parameter int ZQ = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          dir_req,
  input  logic [CW-1:0] offset,
  input  logic [TW-1:0] timeout,
  input  logic          z,
  input  logic          forward,
  input  logic [CW-1:0] cnt,
  output logic          cnt_load,
  output logic [CW-1:0] cnt_load_val,
  output logic [CW-1:0] idx_pos,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int QW = (ZQ < 2) ? 1 : $clog2(ZQ + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_QUAL, S_LOAD, S_DONE, S_FAIL
  } state_t;

  localparam logic [1:0] EC_NONE    = 2'b00;
  localparam logic [1:0] EC_TIMEOUT = 2'b01;
  localparam logic [1:0] EC_ABORT   = 2'b10;

  state_t        state_q, state_d;
  logic          z_meta_q, z_s_q, z_d_q;
  logic [QW-1:0] qual_q, qual_d, qual_inc;
  logic [CW-1:0] offset_q, offset_d;
  logic [CW-1:0] idx_pos_q, idx_pos_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          busy_q, done_q, err_q, cnt_load_q;
  logic          z_rise, timed_out;

  assign z_rise   = z_s_q & ~z_d_q;
  assign qual_inc = qual_q + 1'b1;

`ifdef HOMING_TIMEOUT_EN
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] timeout_q, timeout_d;

  assign timed_out = (timeout_q != '0) && (timer_q >= timeout_q);

  // Timer runs only while seeking/qualifying and saturates at all-ones.
  always_comb begin
    timer_d   = timer_q;
    timeout_d = timeout_q;
    if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL) && start) begin
      timer_d   = '0;
      timeout_d = timeout;
    end else if ((state_q == S_SEEK || state_q == S_QUAL) && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end
`else
  logic [TW-1:0] unused_timeout;
  assign unused_timeout = timeout;
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    qual_d     = qual_q;
    offset_d   = offset_q;
    idx_pos_d  = idx_pos_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d    = S_SEEK;
          offset_d   = offset;
          err_code_d = EC_NONE;
        end
      end
      S_SEEK: begin
        if (abort) begin
          state_d    = S_FAIL;
          err_code_d = EC_ABORT;
        end else if (z_rise && (forward == dir_req)) begin
          idx_pos_d = cnt;
          qual_d    = QW'(1);
          state_d   = (ZQ <= 1) ? S_LOAD : S_QUAL;
        end else if (timed_out) begin
          state_d    = S_FAIL;
          err_code_d = EC_TIMEOUT;
        end
      end
      S_QUAL: begin
        if (abort) begin
          state_d    = S_FAIL;
          err_code_d = EC_ABORT;
        end else if (z_s_q) begin
          qual_d = qual_inc;
          if (qual_inc == QW'(ZQ)) state_d = S_LOAD;
        end else if (timed_out) begin
          state_d    = S_FAIL;
          err_code_d = EC_TIMEOUT;
        end else begin
          state_d = S_SEEK;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d    = S_FAIL;
          err_code_d = EC_ABORT;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      z_meta_q   <= 1'b0;
      z_s_q      <= 1'b0;
      z_d_q      <= 1'b0;
      qual_q     <= '0;
      offset_q   <= '0;
      idx_pos_q  <= '0;
      err_code_q <= EC_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_load_q <= 1'b0;
`ifdef HOMING_TIMEOUT_EN
      timer_q    <= '0;
      timeout_q  <= '0;
`endif
    end else begin
      z_meta_q   <= z;
      z_s_q      <= z_meta_q;
      z_d_q      <= z_s_q;
      state_q    <= state_d;
      qual_q     <= qual_d;
      offset_q   <= offset_d;
      idx_pos_q  <= idx_pos_d;
      err_code_q <= err_code_d;
      busy_q     <= (state_d == S_SEEK) || (state_d == S_QUAL) || (state_d == S_LOAD);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_FAIL);
      cnt_load_q <= (state_d == S_LOAD);
`ifdef HOMING_TIMEOUT_EN
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // An abort arriving during LOAD must still be able to cancel the rebase strobe.
  assign cnt_load     = cnt_load_q & ~abort;
  assign cnt_load_val = offset_q;
  assign idx_pos      = idx_pos_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_homing_sequencer.sv
// Directed bench for homing_sequencer (default parameters, ZQ = 3).
module tb_homing_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, dir_req, z, forward;
  logic [15:0] offset, cnt;
  logic [23:0] timeout;
  logic        cnt_load, busy, done, err;
  logic [15:0] cnt_load_val, idx_pos;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;
  int load_ref;

  homing_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dir_req(dir_req),
    .offset(offset), .timeout(timeout), .z(z), .forward(forward), .cnt(cnt),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .idx_pos(idx_pos),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cnt_load) load_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic dir, input logic [15:0] off, input logic [23:0] tmo);
    dir_req = dir;
    offset  = off;
    timeout = tmo;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; dir_req = 0; z = 0; forward = 0;
    offset = '0; cnt = '0; timeout = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_errcode", err_code, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_idx", idx_pos, 0);
    chk("rst_loadval", cnt_load_val, 0);
    rst = 1'b0;
    tick();

    // Normal homing
    forward = 1; cnt = 16'h1234;
    arm(1'b1, 16'h0100, 24'd0);
    chk("norm_busy", busy, 1);
    chk("norm_done0", done, 0);
    z = 1;
    repeat (3) tick();
    chk("norm_idx", idx_pos, 16'h1234);
    chk("norm_load_early", cnt_load, 0);
    tick();
    chk("norm_load_early2", cnt_load, 0);
    tick();
    chk("norm_load", cnt_load, 1);
    chk("norm_loadval", cnt_load_val, 16'h0100);
    chk("norm_busy_load", busy, 1);
    z = 0;
    tick();
    chk("norm_load_off", cnt_load, 0);
    chk("norm_done", done, 1);
    chk("norm_busy_off", busy, 0);
    chk("norm_errcode", err_code, 0);
    chk("norm_load_count", load_cnt, 1);
    repeat (3) tick();

    // Direction and glitch rejection
    load_ref = load_cnt;
    arm(1'b1, 16'h0200, 24'd0);
    chk("dir_restart_done", done, 0);
    forward = 0; z = 1;
    repeat (4) tick();
    z = 0;
    repeat (6) tick();
    chk("dir_busy", busy, 1);
    chk("dir_done", done, 0);
    forward = 1; z = 1;
    repeat (2) tick();
    z = 0;
    repeat (6) tick();
    chk("glitch_busy", busy, 1);
    chk("glitch_done", done, 0);
    chk("glitch_noload", load_cnt, load_ref);
    cnt = 16'h0055; z = 1;
    repeat (5) tick();
    z = 0;
    repeat (3) tick();
    chk("valid_done", done, 1);
    chk("valid_idx", idx_pos, 16'h0055);
    chk("valid_loadval", cnt_load_val, 16'h0200);
    chk("valid_load_count", load_cnt, load_ref + 1);
    repeat (3) tick();

    // Timeout
`ifdef HOMING_TIMEOUT_EN
    arm(1'b1, 16'h0000, 24'd10);
    chk("tmo_err0", err, 0);
    repeat (10) tick();
    chk("tmo_err_early", err, 0);
    chk("tmo_busy_early", busy, 1);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_errcode", err_code, 2'b01);
    chk("tmo_busy", busy, 0);
    abort = 1; tick(); abort = 0;
    chk("fail_abort_ignored", err_code, 2'b01);
`else
    arm(1'b1, 16'h0000, 24'd10);
    repeat (1000) tick();
    chk("notmo_busy", busy, 1);
    chk("notmo_err", err, 0);
    abort = 1; tick(); abort = 0;
    chk("notmo_abort_err", err, 1);
    chk("notmo_abort_code", err_code, 2'b10);
`endif
    repeat (2) tick();

    // Abort priority over an accepted edge
    load_ref = load_cnt;
    forward = 1;
    arm(1'b1, 16'h0300, 24'd0);
    chk("abrt_clear_err", err, 0);
    chk("abrt_clear_code", err_code, 0);
    z = 1;
    repeat (2) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abrt_err", err, 1);
    chk("abrt_code", err_code, 2'b10);
    chk("abrt_busy", busy, 0);
    repeat (4) tick();
    z = 0;
    chk("abrt_noload", load_cnt, load_ref);
    repeat (3) tick();
    arm(1'b1, 16'h0400, 24'd0);
    chk("rearm_err", err, 0);
    chk("rearm_code", err_code, 0);
    chk("rearm_busy", busy, 1);

    // Reset during QUAL
    z = 1;
    repeat (4) tick();
    rst = 1;
    #2;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_load", cnt_load, 0);
    chk("mrst_loadval", cnt_load_val, 0);
    chk("mrst_idx", idx_pos, 0);
    tick();
    z = 0;
    rst = 0;
    repeat (6) tick();
    chk("mrst_noload", load_cnt, load_ref);
    chk("mrst_idle", busy, 0);

    // Start while busy is ignored
    load_ref = load_cnt;
    cnt = 16'h0777;
    arm(1'b1, 16'h0500, 24'd0);
    arm(1'b1, 16'h0600, 24'd0);
    chk("sb_busy", busy, 1);
    chk("sb_offset", cnt_load_val, 16'h0500);
    z = 1;
    repeat (5) tick();
    z = 0;
    repeat (3) tick();
    chk("sb_done", done, 1);
    chk("sb_loadval", cnt_load_val, 16'h0500);
    chk("sb_load_count", load_cnt, load_ref + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
